// File: rtl/vga_fill_arb.sv
// vga_fill_arb
// Owns the VGA system-bus port and shares it between the CPU and a fill engine.
// The fill engine writes one constant word over a contiguous word range, for
// example to clear the screen or paint a region. The CPU normally wins the port.
// After STARVE_LIM consecutive lost cycles, the engine is forced one slot.
// The engine registers appear where cpu_addr_i[13:12] == 2'b11. Accesses to
// them are answered locally and are never forwarded to the VGA port.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cpu_req_i/we/be/addr/wdata   CPU request side
//   cpu_rdata_o         read data, returned the cycle after an un-stalled read
//   cpu_stall_o         CPU must hold its request (engine took the slot)
//   vga_req_o/we/be/addr/wdata   request to the VGA controller
//   vga_rdata_i         VGA read data, valid the cycle after a read request
//   done_o              one-cycle pulse after the last fill word is issued
//
// Register map (word offset on cpu_addr_i[3:2])
//   0 DST   fill start byte address (bits[1:0] forced to 0)
//   1 LEN   word count
//   2 DATA  fill word
//   3 CTRL  write: bit0 start, bit1 abort
//     STAT  read : bit0 busy, bits[LEN_W+15:16] remaining words
module vga_fill_arb #(
  parameter int LEN_W      = 12,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        vga_req_o,
  output logic        vga_we_o,
  output logic [3:0]  vga_be_o,
  output logic [31:0] vga_addr_o,
  output logic [31:0] vga_wdata_o,
  input  logic [31:0] vga_rdata_i,
  output logic        done_o
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_data;
  logic [31:0]      r_ptr;
  logic [LEN_W-1:0] r_remaining;
  logic [SW-1:0]    r_starve;
  logic             r_done;
  logic             r_rd_pend;
  logic             r_rd_vga;
  logic [31:0]      r_reg_rdata;
  logic [31:0]      r_rdata_hold;

  logic             w_reg_sel;
  logic             w_cpu_vga;
  logic             w_reg_wr;
  logic             w_ctrl_wr;
  logic             w_busy;
  logic             w_start;
  logic             w_abort;
  logic             w_starved;
  logic             w_eng_grant;
  logic             w_last_word;
  logic             w_cpu_rd_ok;
  logic [31:0]      w_stat;
  logic [31:0]      w_reg_val;
  logic             w_unused;

  // Only the window select and word offset bits take part in the decode.
  assign w_unused = ^{cpu_addr_i[31:14], cpu_addr_i[11:4], cpu_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Decode and arbitration
  // ---------------------------------------------------------------------------
  assign w_reg_sel   = (cpu_addr_i[13:12] == 2'b11);
  assign w_cpu_vga   = cpu_req_i & ~w_reg_sel;
  assign w_reg_wr    = cpu_req_i & cpu_we_i & w_reg_sel;
  assign w_ctrl_wr   = w_reg_wr & (cpu_addr_i[3:2] == 2'd3);
  assign w_busy      = (r_state == S_RUN);

  // Abort beats start when both bits are set in the same write.
  assign w_start     = w_ctrl_wr & cpu_wdata_i[0] & ~cpu_wdata_i[1] &
                       ~w_busy & (r_len != '0);
  assign w_abort     = w_ctrl_wr & cpu_wdata_i[1] & w_busy;

  assign w_starved   = (r_starve == SW'(STARVE_LIM));
  assign w_eng_grant = w_busy & (~w_cpu_vga | w_starved);
  assign w_last_word = w_eng_grant & (r_remaining == LEN_W'(1));

  // A CPU read completes whenever it is not stalled. Register reads never stall.
  assign w_cpu_rd_ok = cpu_req_i & ~cpu_we_i & ~(w_cpu_vga & w_eng_grant);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort || w_last_word) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (VGA port mux, stall, read-data return)
  // ---------------------------------------------------------------------------
  always_comb begin
    vga_req_o   = 1'b0;
    vga_we_o    = 1'b0;
    vga_be_o    = 4'h0;
    vga_addr_o  = 32'h0;
    vga_wdata_o = 32'h0;
    if (w_eng_grant) begin
      vga_req_o   = 1'b1;
      vga_we_o    = 1'b1;
      vga_be_o    = 4'hF;
      vga_addr_o  = r_ptr;
      vga_wdata_o = r_data;
    end else if (w_cpu_vga) begin
      vga_req_o   = 1'b1;
      vga_we_o    = cpu_we_i;
      vga_be_o    = cpu_be_i;
      vga_addr_o  = cpu_addr_i;
      vga_wdata_o = cpu_wdata_i;
    end

    cpu_stall_o = w_cpu_vga & w_eng_grant;

    // Outside a read-return cycle the bus keeps showing the last returned word.
    if (r_rd_pend) begin
      cpu_rdata_o = r_rd_vga ? vga_rdata_i : r_reg_rdata;
    end else begin
      cpu_rdata_o = r_rdata_hold;
    end
  end

  assign done_o = r_done;

  // ---------------------------------------------------------------------------
  // Register read value, sampled in the request cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stat                = 32'h0;
    w_stat[LEN_W+15:16]   = r_remaining;
    w_stat[0]             = w_busy;
    case (cpu_addr_i[3:2])
      2'd0:    w_reg_val = r_dst;
      2'd1:    w_reg_val = 32'(r_len);
      2'd2:    w_reg_val = r_data;
      default: w_reg_val = w_stat;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Configuration registers (frozen while a fill is running)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dst  <= 32'h0;
      r_len  <= '0;
      r_data <= 32'h0;
    end else if (w_reg_wr && !w_busy) begin
      case (cpu_addr_i[3:2])
        2'd0:    r_dst  <= {cpu_wdata_i[31:2], 2'b00};
        2'd1:    r_len  <= cpu_wdata_i[LEN_W-1:0];
        2'd2:    r_data <= cpu_wdata_i;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Fill engine datapath and starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr       <= 32'h0;
      r_remaining <= '0;
      r_starve    <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_ptr       <= r_dst;
        r_remaining <= r_len;
        r_starve    <= '0;
      end else if (w_abort) begin
        // A grant in the abort cycle still goes out. Nothing is left to count.
        r_remaining <= '0;
        r_starve    <= '0;
      end else if (w_eng_grant) begin
        r_ptr       <= r_ptr + 32'd4;
        r_remaining <= r_remaining - LEN_W'(1);
        r_starve    <= '0;
      end else if (w_busy && w_cpu_vga && !w_starved) begin
        r_starve    <= r_starve + SW'(1);
      end
      r_done <= w_last_word & ~w_abort;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_pend    <= 1'b0;
      r_rd_vga     <= 1'b0;
      r_reg_rdata  <= 32'h0;
      r_rdata_hold <= 32'h0;
    end else begin
      r_rd_pend    <= w_cpu_rd_ok;
      r_rdata_hold <= cpu_rdata_o;
      if (w_cpu_rd_ok) begin
        r_rd_vga    <= w_cpu_vga;
        r_reg_rdata <= w_reg_val;
      end
    end
  end

endmodule

// File: tb/tb_vga_fill_arb.sv
// Bench for vga_fill_arb. A queue-based model predicts every output on each
// cycle. Directed scenarios add literal expectations on the logged VGA traffic.
module tb_vga_fill_arb;

  localparam int          LEN_W      = 12;
  localparam int          STARVE_LIM = 8;
  localparam logic [31:0] REG_BASE   = 32'h0000_3000;

  logic        clk_i       = 1'b0;
  logic        rst_i       = 1'b1;
  logic        cpu_req_i   = 1'b0;
  logic        cpu_we_i    = 1'b0;
  logic [3:0]  cpu_be_i    = 4'h0;
  logic [31:0] cpu_addr_i  = 32'h0;
  logic [31:0] cpu_wdata_i = 32'h0;
  logic [31:0] vga_rdata_i = 32'h0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        vga_req_o;
  logic        vga_we_o;
  logic [3:0]  vga_be_o;
  logic [31:0] vga_addr_o;
  logic [31:0] vga_wdata_o;
  logic        done_o;

  vga_fill_arb #(.LEN_W(LEN_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_be_i    (cpu_be_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .vga_req_o   (vga_req_o),
    .vga_we_o    (vga_we_o),
    .vga_be_o    (vga_be_o),
    .vga_addr_o  (vga_addr_o),
    .vga_wdata_o (vga_wdata_o),
    .vga_rdata_i (vga_rdata_i),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the pending fill is a queue of word addresses still to be written.
  // ---------------------------------------------------------------------------
  logic [31:0]      m_q[$];
  logic [31:0]      m_dst     = 32'h0;
  logic [31:0]      m_data    = 32'h0;
  logic [LEN_W-1:0] m_len     = '0;
  int               m_lost    = 0;
  bit               m_done    = 1'b0;
  bit               m_rd_pend = 1'b0;
  bit               m_rd_vga  = 1'b0;
  logic [31:0]      m_regval  = 32'h0;
  logic [31:0]      m_last    = 32'h0;

  function automatic bit f_reg_hit(input logic [31:0] a);
    return a[13:12] == 2'b11;
  endfunction

  function automatic bit f_cpu_vga();
    return cpu_req_i && !f_reg_hit(cpu_addr_i);
  endfunction

  function automatic bit f_grant();
    return (m_q.size() != 0) && (!f_cpu_vga() || m_lost >= STARVE_LIM);
  endfunction

  function automatic logic [31:0] f_shown();
    if (!m_rd_pend) return m_last;
    return m_rd_vga ? vga_rdata_i : m_regval;
  endfunction

  function automatic logic [31:0] f_regread(input logic [1:0] off);
    logic [31:0] s;
    case (off)
      2'd0:    return m_dst;
      2'd1:    return 32'(m_len);
      2'd2:    return m_data;
      default: begin
        s = 32'(m_q.size()) << 16;
        if (m_q.size() != 0) s[0] = 1'b1;
        return s;
      end
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q.delete();
      m_dst     = 32'h0;
      m_data    = 32'h0;
      m_len     = '0;
      m_lost    = 0;
      m_done    = 1'b0;
      m_rd_pend = 1'b0;
      m_rd_vga  = 1'b0;
      m_regval  = 32'h0;
      m_last    = 32'h0;
    end else begin
      bit          cv;
      bit          g;
      bit          busy;
      logic [31:0] shown;
      cv    = f_cpu_vga();
      g     = f_grant();
      busy  = (m_q.size() != 0);
      shown = f_shown();
      m_last = shown;
      if (cpu_req_i && !cpu_we_i && !(cv && g)) begin
        m_rd_pend = 1'b1;
        m_rd_vga  = cv;
        m_regval  = f_regread(cpu_addr_i[3:2]);
      end else begin
        m_rd_pend = 1'b0;
      end
      m_done = g && (m_q.size() == 1);
      if (g) begin
        m_q.delete(0);
        m_lost = 0;
      end else if (busy && cv && m_lost < STARVE_LIM) begin
        m_lost++;
      end
      if (cpu_req_i && cpu_we_i && f_reg_hit(cpu_addr_i)) begin
        case (cpu_addr_i[3:2])
          2'd0: if (!busy) m_dst = {cpu_wdata_i[31:2], 2'b00};
          2'd1: if (!busy) m_len = cpu_wdata_i[LEN_W-1:0];
          2'd2: if (!busy) m_data = cpu_wdata_i;
          default: begin
            if (cpu_wdata_i[1]) begin
              if (busy) begin
                m_q.delete();
                m_done = 1'b0;
              end
            end else if (cpu_wdata_i[0] && !busy && m_len != 0) begin
              for (int i = 0; i < int'(m_len); i++) m_q.push_back(m_dst + 32'(4 * i));
              m_lost = 0;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      bit cv;
      bit g;
      cv = f_cpu_vga();
      g  = f_grant();
      chk("vga_req",   32'(vga_req_o),   32'(g || cv));
      chk("vga_we",    32'(vga_we_o),    g ? 32'd1 : (cv ? 32'(cpu_we_i) : 32'd0));
      chk("vga_be",    32'(vga_be_o),    g ? 32'hF : (cv ? 32'(cpu_be_i) : 32'd0));
      chk("vga_addr",  vga_addr_o,       g ? m_q[0] : (cv ? cpu_addr_i : 32'h0));
      chk("vga_wdata", vga_wdata_o,      g ? m_data : (cv ? cpu_wdata_i : 32'h0));
      chk("cpu_stall", 32'(cpu_stall_o), 32'(cv && g));
      chk("done",      32'(done_o),      32'(m_done));
      chk("cpu_rdata", cpu_rdata_o,      f_shown());
    end
  end

  // ---------------------------------------------------------------------------
  // Traffic log for directed checks
  // ---------------------------------------------------------------------------
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  bit          log_stall[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          n_vga_rd = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (vga_req_o && vga_we_o) begin
        log_addr.push_back(vga_addr_o);
        log_data.push_back(vga_wdata_o);
        log_cyc.push_back(cyc);
        log_stall.push_back(cpu_stall_o);
      end
      if (vga_req_o && !vga_we_o) n_vga_rd++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    log_stall.delete();
    done_cnt = 0;
    n_vga_rd = 0;
  endtask

  // Read data from the VGA side changes every cycle so stale returns show up.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      vga_rdata_i = 32'hDA7A_0000 + 32'(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] off, input logic [31:0] d);
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_be_i    = 4'hF;
    cpu_addr_i  = REG_BASE | {28'd0, off, 2'b00};
    cpu_wdata_i = d;
    cycle();
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_wdata_i = 32'h0;
    $display("reg wr off=%0d data=0x%08h", off, d);
  endtask

  task automatic reg_rd(input logic [1:0] off, output logic [31:0] val);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_be_i   = 4'hF;
    cpu_addr_i = REG_BASE | {28'd0, off, 2'b00};
    cycle();
    cpu_req_i  = 1'b0;
    @(negedge clk_i);
    val = cpu_rdata_o;
    $display("reg rd off=%0d data=0x%08h", off, val);
    cycle();
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) cycle();
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rv;
    int          start_cyc;
    int          bad;

    // Reset state
    @(negedge clk_i);
    chk("rst_vga_req",   32'(vga_req_o),   32'd0);
    chk("rst_vga_addr",  vga_addr_o,       32'h0);
    chk("rst_stall",     32'(cpu_stall_o), 32'd0);
    chk("rst_done",      32'(done_o),      32'd0);
    chk("rst_rdata",     cpu_rdata_o,      32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(2);

    // Basic fill: four consecutive writes, done the cycle after the last.
    reg_wr(2'd0, 32'h0000_0000);
    reg_wr(2'd1, 32'd4);
    reg_wr(2'd2, 32'h4141_4141);
    clear_log();
    reg_wr(2'd3, 32'h1);
    start_cyc = cyc;
    wait_done("basic_done_timeout", 1, 20);
    idle(2);
    chk("basic_count", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      chk("basic_addr0", log_addr[0], 32'h0);
      chk("basic_addr1", log_addr[1], 32'h4);
      chk("basic_addr2", log_addr[2], 32'h8);
      chk("basic_addr3", log_addr[3], 32'hC);
      chk("basic_data",  log_data[0], 32'h4141_4141);
      chk("basic_first_cycle", 32'(log_cyc[0] - start_cyc), 32'd0);
      chk("basic_back_to_back", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
      chk("basic_done_cycle", 32'(done_cyc - log_cyc[3]), 32'd1);
    end
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    reg_rd(2'd3, rv);
    chk("basic_stat", rv, 32'h0);

    // CPU priority with continuous VGA reads: 8 CPU cycles, then 1 engine slot.
    reg_wr(2'd0, 32'h0000_0100);
    reg_wr(2'd1, 32'd20);
    reg_wr(2'd2, 32'h55AA_55AA);
    clear_log();
    reg_wr(2'd3, 32'h1);
    start_cyc  = cyc;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_be_i   = 4'hF;
    cpu_addr_i = 32'h0000_1000;
    for (int i = 0; i < 300 && done_cnt < 1; i++) cycle();
    cpu_req_i  = 1'b0;
    chk("prio_done_timeout", 32'(done_cnt >= 1), 32'd1);
    idle(2);
    chk("prio_count", 32'(log_addr.size()), 32'd20);
    if (log_addr.size() == 20) begin
      chk("prio_first_slot", 32'(log_cyc[0] - start_cyc), 32'd8);
      bad = 0;
      for (int i = 1; i < 20; i++) if (log_cyc[i] - log_cyc[i-1] != 9) bad++;
      chk("prio_gap9", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) if (!log_stall[i]) bad++;
      chk("prio_stall_each_slot", 32'(bad), 32'd0);
      chk("prio_last_addr", log_addr[19], 32'h0000_014C);
    end

    // Register path during RUN: STAT after three words.
    reg_wr(2'd0, 32'h0000_2000);
    reg_wr(2'd1, 32'd10);
    clear_log();
    reg_wr(2'd3, 32'h1);
    idle(3);
    reg_rd(2'd3, rv);
    chk("stat_mid_run", rv, 32'h0007_0001);
    wait_done("regpath_done_timeout", 1, 30);
    idle(2);
    chk("regpath_count", 32'(log_addr.size()), 32'd10);
    if (log_addr.size() == 10) chk("regpath_last_addr", log_addr[9], 32'h0000_2024);
    chk("regpath_no_vga_read", 32'(n_vga_rd), 32'd0);

    // Start with LEN=0 is a no-op.
    reg_wr(2'd1, 32'd0);
    clear_log();
    reg_wr(2'd3, 32'h1);
    idle(5);
    chk("len0_writes", 32'(log_addr.size()), 32'd0);
    chk("len0_done",   32'(done_cnt), 32'd0);
    reg_rd(2'd3, rv);
    chk("len0_stat",   rv, 32'h0);

    // Address wrap across the top of the 32-bit space.
    reg_wr(2'd0, 32'hFFFF_FFFC);
    reg_wr(2'd1, 32'd2);
    clear_log();
    reg_wr(2'd3, 32'h1);
    wait_done("wrap_done_timeout", 1, 10);
    idle(2);
    chk("wrap_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", log_addr[1], 32'h0000_0000);
    end

    // Config writes during RUN are ignored.
    reg_wr(2'd0, 32'h0000_0400);
    reg_wr(2'd1, 32'd6);
    reg_wr(2'd2, 32'h1234_5678);
    clear_log();
    reg_wr(2'd3, 32'h1);
    reg_wr(2'd2, 32'hDEAD_BEEF);
    reg_wr(2'd1, 32'd1);
    wait_done("ignore_done_timeout", 1, 20);
    idle(2);
    chk("ignore_count", 32'(log_addr.size()), 32'd6);
    bad = 0;
    for (int i = 0; i < log_data.size(); i++) if (log_data[i] != 32'h1234_5678) bad++;
    chk("ignore_data_kept", 32'(bad), 32'd0);
    reg_rd(2'd2, rv);
    chk("ignore_data_reg", rv, 32'h1234_5678);

    // Abort after two of six words.
    reg_wr(2'd0, 32'h0000_0800);
    clear_log();
    reg_wr(2'd3, 32'h1);
    cycle();
    reg_wr(2'd3, 32'h2);
    idle(5);
    chk("abort_count", 32'(log_addr.size()), 32'd2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    reg_rd(2'd3, rv);
    chk("abort_stat", rv, 32'h0);

    // Reset in the middle of a fill.
    reg_wr(2'd0, 32'h0000_0C00);
    reg_wr(2'd1, 32'd8);
    reg_wr(2'd3, 32'h1);
    idle(2);
    chk("pre_reset_req", 32'(vga_req_o), 32'd1);
    #2;
    rst_i = 1'b1;
    clear_log();
    #1;
    chk("reset_req_async", 32'(vga_req_o), 32'd0);
    chk("reset_done_async", 32'(done_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    reg_rd(2'd3, rv);
    chk("reset_stat", rv, 32'h0);
    idle(10);
    chk("reset_no_writes", 32'(log_addr.size()), 32'd0);
    chk("reset_no_done",   32'(done_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fill_arb.md
Name: vga_fill_arb

Overview:
- Sits between the core's system-bus port and the VGA system-bus controller; owns the VGA bus.
- Contains a memory fill engine that writes a constant word over a contiguous range of the VGA character, colour or font memories, e.g. for screen clear or region paint.
- Arbitrates each cycle between CPU accesses and engine writes: CPU has priority, with a starvation guard for the engine.
- Engine registers occupy the otherwise unused offset window 0x3000-0x300F of the VGA address range.

Parameters:
- LEN_W, 12: width of the word-count register; max fill 2^LEN_W-1 words.
- STARVE_LIM, 8: consecutive engine-pending cycles lost to the CPU before the engine is forced one slot.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- cpu_req_i  in  1  CPU request to VGA window
- cpu_we_i  in  1  CPU write enable
- cpu_be_i  in  4  CPU byte enables
- cpu_addr_i  in  32  CPU byte address
- cpu_wdata_i  in  32  CPU write data
- cpu_rdata_o  out  32  CPU read data, valid cycle after request
- cpu_stall_o  out  1  CPU must hold request this cycle
- vga_req_o  out  1  request to VGA controller
- vga_we_o  out  1  write enable to VGA controller
- vga_be_o  out  4  byte enables to VGA controller
- vga_addr_o  out  32  address to VGA controller
- vga_wdata_o  out  32  write data to VGA controller
- vga_rdata_i  in  32  VGA read data, valid cycle after request
- done_o  out  1  one-cycle pulse after last fill word issued

Behaviour:
- Reset (async, rst_i=1): state IDLE; dst, len, data, remaining, starve counter = 0; all outputs = 0.
- Decode: reg_sel = (cpu_addr_i[13:12] == 2'b11). Register hits never reach the VGA port.
- Registers are word offsets on cpu_addr_i[3:2]; full-word writes only, cpu_be_i ignored.
  - 0 DST: fill start byte address; bits[1:0] forced 0.
  - 1 LEN: word count, LEN_W bits.
  - 2 DATA: fill word.
  - 3 CTRL/STAT write: bit0 = start, bit1 = abort.
  - 3 CTRL/STAT read: bit0 = busy, bits[LEN_W+15:16] = remaining.
- Register reads return on cpu_rdata_o the next cycle. Writes take effect at the clock edge.
- Writes to DST/LEN/DATA while busy are ignored. Start while busy is ignored.
- Start with LEN=0: no-op; busy stays 0; no done_o pulse.
- FSM:
  - IDLE -> RUN on start with LEN != 0; loads ptr = DST, remaining = LEN, starve = 0.
  - RUN -> IDLE on the grant that issues the last word (remaining 1 -> 0); done_o = 1 the following cycle.
  - RUN -> IDLE on abort; no done_o.
  - Abort and start in the same write: abort wins.
- Arbitration, combinational per cycle:
  - cpu_vga = cpu_req_i & ~reg_sel.
  - eng_grant = RUN & (~cpu_vga | starve == STARVE_LIM).
  - cpu_stall_o = cpu_vga & eng_grant.
  - Register accesses never stall and can coincide with an engine grant.
- starve counter:
  - Increments when RUN & cpu_vga & ~eng_grant.
  - Clears on any eng_grant.
  - Saturates at STARVE_LIM.
- VGA port drive:
  - On eng_grant: vga_req_o=1, we=1, be=4'hF, addr=ptr, wdata=DATA. Then ptr += 4 (32-bit wrap, no error) and remaining -= 1.
  - Else if cpu_vga: pass CPU signals straight through.
  - Else: vga_req_o=0, other outputs 0.
- Read-data mux select is registered (1 = VGA read, 0 = register read) from the cycle of the un-stalled CPU read. cpu_rdata_o = vga_rdata_i or the register value accordingly. Outside a read-return cycle, cpu_rdata_o holds its last value.
- Throughput: one engine word per cycle with no CPU traffic. Under continuous CPU traffic, at least one engine word per STARVE_LIM+1 cycles.
- Reset mid-RUN: immediate return to IDLE, vga_req_o drops asynchronously, no done_o.

Test Plan:
- Basic fill: DST=0x0000, LEN=4, DATA=0x41414141, start, no CPU traffic -> vga writes at 0x0,0x4,0x8,0xC on 4 consecutive cycles, be=F; done_o pulses the cycle after; STAT.busy=0.
- CPU priority: fill LEN=20 with cpu_req_i held to 0x1000 reads, STARVE_LIM=8 -> 8 CPU cycles pass through, 1 engine write with cpu_stall_o=1, repeat; CPU read data correct after each un-stalled cycle.
- Register path: read STAT during RUN with LEN=10 after 3 words -> cpu_rdata_o[27:16]=7, bit0=1 next cycle; no vga_req_o from the register access.
- Edge cases: start with LEN=0 -> no VGA traffic, no done_o. DST=0xFFFFFFFC, LEN=2 -> addresses 0xFFFFFFFC then 0x00000000.
- Abort/ignore: write DATA during RUN -> fill word unchanged. Abort after 2 of 6 words -> exactly 2 writes, no done_o, busy=0.
- Reset mid-operation: assert rst_i during RUN between clock edges -> vga_req_o=0 immediately; after release, STAT=0 and no further writes.
